free_list_nway: RTL and testbench
=================================

Name: free_list_nway

Overview:
- Parametrised physical-register free list for the renaming stage of the out-of-order RISC-V core. Successor to the single-port free list.
- Circular buffer of free physical tags with N-wide allocation and M-wide release.
- Keeps two heads: a speculative head advanced by rename, and an architectural head advanced by commit.
- Restores the speculative head on pipeline flush, so tags allocated on the wrong path return to the list without being re-freed.

Parameters:
- NUM_PHYS, 64, total physical registers; TAG_W = $clog2(NUM_PHYS).
- NUM_ARCH, 32, architectural registers, mapped at reset; tags 0..NUM_ARCH-1 are never in the list at reset.
- DEPTH, NUM_PHYS-NUM_ARCH, list capacity; must be a power of two.
- ALLOC_W, 2, allocation lanes per cycle.
- FREE_W, 2, release lanes per cycle.
- CNT_W, $clog2(DEPTH)+1, count and pointer width (includes wrap bit).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; dominates all other inputs.
- alloc_num  in  $clog2(ALLOC_W+1)  number of tags requested this cycle.
- alloc_grant  out  1  request satisfied (all-or-nothing).
- alloc_tag  out  ALLOC_W x TAG_W  tags at speculative head, lane 0 oldest.
- free_valid  in  FREE_W  per-lane release valid.
- free_tag  in  FREE_W x TAG_W  released tags.
- commit_num  in  $clog2(ALLOC_W+1)  allocations retired this cycle.
- flush  in  1  squash all speculative allocations.
- free_count  out  CNT_W  tags available to rename (tail - spec_head).
- empty  out  1  free_count == 0.
- error  out  1  sticky protocol violation flag.

Behaviour:
- Reset (one cycle, synchronous):
  - entry[i] = NUM_ARCH+i.
  - spec_head = arch_head = 0; tail = DEPTH (wrap bit set, list full).
  - free_count = DEPTH, empty = 0, error = 0.
- Pointers are CNT_W bits. Index = low $clog2(DEPTH) bits. Wrap by natural overflow. Occupancy = tail - ptr, unsigned.
- Allocation, lookahead (first-word fall-through):
  - alloc_tag[k] = entry[spec_head+k] combinationally.
  - Tag lanes at or beyond free_count are don't-care.
  - alloc_grant = (alloc_num != 0) && (alloc_num <= free_count) && !flush.
  - On grant, spec_head += alloc_num at the edge. No grant means no pointer change and no partial allocation.
- Release:
  - Valid lanes are compacted in lane order. They are written at tail, tail+1, ...; tail += popcount(free_valid).
  - Released tags become allocatable the next cycle. There is no same-cycle bypass.
- Commit:
  - arch_head += commit_num.
  - commit_num > (spec_head - arch_head) sets error; arch_head is unchanged.
- Flush:
  - spec_head <= arch_head after that cycle's commit is applied.
  - Allocation is suppressed (grant 0).
  - Frees and commit in the flush cycle are still performed.
- Overflow: (tail - arch_head) + popcount(free_valid) > DEPTH sets error. The whole release is dropped and tail is unchanged.
- error stays set until reset. Free, alloc and commit all proceed independently in one cycle.
- empty and free_count are registered-state derived: they reflect pointers after the last edge.

Decomposition:
- free_list_pkg holds:
  - NUM_PHYS, NUM_ARCH, DEPTH, TAG_W, CNT_W;
  - the typedefs phys_tag_t and fl_ptr_t;
  - the function popcount_free.
- One sub-module, free_list_compact: FREE_W-lane valid/tag compaction producing packed tags and a count. It is combinational and instantiated once.
- Storage array and pointer logic live in the top module.

Test Plan (default parameters):
- Post-reset drain:
  - Stimulus: reset, then alloc_num=2 every cycle.
  - Cycle 1 tags 32,33; cycle 2 tags 34,35.
  - After 16 grants: empty=1, free_count=0; 17th request gives grant=0.
- All-or-nothing:
  - Stimulus: drain to free_count=1, then alloc_num=2.
  - Grant=0 and head holds. Next cycle alloc_num=1 gives grant=1 and tag 63.
- Compaction:
  - Stimulus: from free_count=0, free_valid=2'b10, free_tag[1]=5.
  - Next cycle free_count=1; alloc_num=1 returns tag 5.
  - Then free_valid=2'b11 with tags 9,8 returns 9 then 8.
- Flush recovery:
  - Stimulus: after reset, allocate 6 tags (32..37), commit_num=2, then flush.
  - Next cycle free_count=30; alloc_num=1 returns tag 34.
- Simultaneous at empty:
  - Stimulus: free_count=0, free tag 7 and alloc_num=1 in the same cycle.
  - Grant=0. Next cycle grant=1 with tag 7.
- Errors:
  - Stimulus: right after reset, free one tag.
  - error=1, free_count stays 32.
  - Then commit_num=1 with no allocations: error stays 1.
  - Reset clears error.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared definitions for the N-wide physical-register free list.
// Holds the list geometry, tag and pointer types, and the release popcount.
package free_list_pkg;

    localparam int unsigned NUM_PHYS  = 64;
    localparam int unsigned NUM_ARCH  = 32;
    localparam int unsigned DEPTH     = NUM_PHYS - NUM_ARCH;
    localparam int unsigned TAG_W     = $clog2(NUM_PHYS);
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    // Widest release port popcount_free can count.
    localparam int unsigned MAX_LANES = 8;

    typedef logic [TAG_W-1:0] phys_tag_t;
    typedef logic [CNT_W-1:0] fl_ptr_t;

    // Number of valid release lanes; unused upper lanes must be zero.
    function automatic fl_ptr_t popcount_free(input logic [MAX_LANES-1:0] valid);
        fl_ptr_t cnt;
        cnt = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            cnt = cnt + fl_ptr_t'(valid[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/free_list_compact.sv
// Release-lane compaction for the free list.
// Ports:
//   valid      - per-lane release valid
//   tag        - per-lane released tag
//   packed_tag - valid tags packed toward lane 0, lane order preserved
//   count      - number of valid lanes
module free_list_compact
    import free_list_pkg::*;
#(
    parameter int unsigned FREE_W = 2
) (
    input  logic      [FREE_W-1:0] valid,
    input  phys_tag_t [FREE_W-1:0] tag,
    output phys_tag_t [FREE_W-1:0] packed_tag,
    output fl_ptr_t                count
);

    logic [MAX_LANES-1:0] valid_pad;

    // Output slot o takes the lane whose rank among valid lanes equals o.
    always_comb begin
        packed_tag = '0;
        for (int unsigned o = 0; o < FREE_W; o++) begin
            int unsigned rank;
            rank = 0;
            for (int unsigned i = 0; i < FREE_W; i++) begin
                if (valid[i]) begin
                    if (rank == o) begin
                        packed_tag[o] = tag[i];
                    end
                    rank = rank + 1;
                end
            end
        end
    end

    always_comb begin
        valid_pad             = '0;
        valid_pad[FREE_W-1:0] = valid;
        count                 = popcount_free(valid_pad);
    end

endmodule

// File: rtl/free_list_nway.sv
// Physical-register free list with ALLOC_W-wide allocation and FREE_W-wide release.
// Circular buffer with a speculative head (rename), an architectural head
// (commit) and a tail (release). Flush rewinds the speculative head.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   alloc_num      - tags requested this cycle; alloc_grant all-or-nothing
//   alloc_tag      - lookahead tags at the speculative head, lane 0 oldest
//   free_valid/tag - released tags, compacted in lane order
//   commit_num     - allocations retired this cycle
//   flush          - squash speculative allocations
//   free_count     - tags available to rename; empty when zero
//   error          - sticky protocol violation (over-commit or overflow)
module free_list_nway
    import free_list_pkg::*;
#(
    parameter int unsigned ALLOC_W = 2,
    parameter int unsigned FREE_W  = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [$clog2(ALLOC_W+1)-1:0]   alloc_num,
    output logic                           alloc_grant,
    output phys_tag_t [ALLOC_W-1:0]        alloc_tag,
    input  logic [FREE_W-1:0]              free_valid,
    input  phys_tag_t [FREE_W-1:0]         free_tag,
    input  logic [$clog2(ALLOC_W+1)-1:0]   commit_num,
    input  logic                           flush,
    output fl_ptr_t                        free_count,
    output logic                           empty,
    output logic                           error
);

    phys_tag_t entry [DEPTH];
    fl_ptr_t   spec_head;
    fl_ptr_t   arch_head;
    fl_ptr_t   tail;
    logic      error_q;

    phys_tag_t [FREE_W-1:0] rel_tag;
    fl_ptr_t                rel_cnt;
    fl_ptr_t                alloc_ext;
    fl_ptr_t                commit_ext;
    fl_ptr_t                arch_next;
    logic                   commit_bad;
    logic [CNT_W:0]         rel_occ;
    logic                   overflow;
    logic [IDX_W-1:0]       wr_idx [FREE_W];

    free_list_compact #(
        .FREE_W (FREE_W)
    ) u_compact (
        .valid      (free_valid),
        .tag        (free_tag),
        .packed_tag (rel_tag),
        .count      (rel_cnt)
    );

    always_comb begin
        fl_ptr_t rd_ptr;
        rd_ptr     = '0;
        free_count = tail - spec_head;
        empty      = (free_count == '0);
        error      = error_q;
        alloc_ext  = fl_ptr_t'(alloc_num);
        commit_ext = fl_ptr_t'(commit_num);
        alloc_grant = (alloc_num != '0) && (alloc_ext <= free_count) && !flush;
        for (int unsigned k = 0; k < ALLOC_W; k++) begin
            rd_ptr       = spec_head + fl_ptr_t'(k);
            alloc_tag[k] = entry[rd_ptr[IDX_W-1:0]];
        end
    end

    // Commit may only retire what rename has handed out; a bad commit is ignored.
    always_comb begin
        commit_bad = commit_ext > (spec_head - arch_head);
        arch_next  = commit_bad ? arch_head : arch_head + commit_ext;
    end

    // Occupancy is measured against the architectural head: speculatively
    // allocated tags still hold their slots until commit.
    always_comb begin
        fl_ptr_t wr_ptr;
        wr_ptr   = '0;
        rel_occ  = {1'b0, tail - arch_head} + {1'b0, rel_cnt};
        overflow = rel_occ > (CNT_W+1)'(DEPTH);
        for (int unsigned j = 0; j < FREE_W; j++) begin
            wr_ptr    = tail + fl_ptr_t'(j);
            wr_idx[j] = wr_ptr[IDX_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry[i] <= phys_tag_t'(NUM_ARCH + i);
            end
            spec_head <= '0;
            arch_head <= '0;
            tail      <= fl_ptr_t'(DEPTH);
            error_q   <= 1'b0;
        end else begin
            if (flush) begin
                spec_head <= arch_next;
            end else if (alloc_grant) begin
                spec_head <= spec_head + alloc_ext;
            end
            arch_head <= arch_next;
            if (!overflow) begin
                for (int unsigned j = 0; j < FREE_W; j++) begin
                    if (fl_ptr_t'(j) < rel_cnt) begin
                        entry[wr_idx[j]] <= rel_tag[j];
                    end
                end
                tail <= tail + rel_cnt;
            end
            if (overflow || commit_bad) begin
                error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_free_list_nway.sv
module tb_free_list_nway;
    import free_list_pkg::*;

    logic                clock = 1'b0;
    logic                reset;
    logic [1:0]          alloc_num;
    logic                alloc_grant;
    phys_tag_t [1:0]     alloc_tag;
    logic [1:0]          free_valid;
    phys_tag_t [1:0]     free_tag;
    logic [1:0]          commit_num;
    logic                flush;
    fl_ptr_t             free_count;
    logic                empty;
    logic                error;

    int unsigned checks = 0;
    int unsigned passed = 0;
    phys_tag_t   exp_q[$];
    phys_tag_t   e;

    always #5 clock = ~clock;

    free_list_nway #(
        .ALLOC_W (2),
        .FREE_W  (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_num   (alloc_num),
        .alloc_grant (alloc_grant),
        .alloc_tag   (alloc_tag),
        .free_valid  (free_valid),
        .free_tag    (free_tag),
        .commit_num  (commit_num),
        .flush       (flush),
        .free_count  (free_count),
        .empty       (empty),
        .error       (error)
    );

    function automatic phys_tag_t exp_pop();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic drive(input int unsigned num, input logic [1:0] fv, input phys_tag_t t0,
                         input phys_tag_t t1, input int unsigned cn, input logic fl);
        alloc_num   = 2'(num);
        free_valid  = fv;
        free_tag[0] = t0;
        free_tag[1] = t1;
        commit_num  = 2'(cn);
        flush       = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        drive(0, 2'b00, '0, '0, 0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 2'b00, '0, '0, 0, 1'b0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        for (int i = 32; i < 64; i++) exp_q.push_back(phys_tag_t'(i));
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (free_count !== fl_ptr_t'(32)) $display("FAIL reset_count: got %0d want 32", free_count); else passed++;
        checks++; if (empty !== 1'b0) $display("FAIL reset_empty: got %0b want 0", empty); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL reset_error: got %0b want 0", error); else passed++;
        checks++; if (alloc_tag[0] !== phys_tag_t'(32)) $display("FAIL reset_lookahead: got %0d want 32", alloc_tag[0]); else passed++;
    endtask

    task automatic test_drain();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(2, 2'b00, '0, '0, 0, 1'b0);
            checks++; if (alloc_grant !== 1'b1) $display("FAIL drain_grant c%0d: got %0b want 1", c, alloc_grant); else passed++;
            e = exp_pop();
            checks++; if (alloc_tag[0] !== e) $display("FAIL drain_tag0 c%0d: got %0d want %0d", c, alloc_tag[0], e); else passed++;
            e = exp_pop();
            checks++; if (alloc_tag[1] !== e) $display("FAIL drain_tag1 c%0d: got %0d want %0d", c, alloc_tag[1], e); else passed++;
            tick();
        end
        checks++; if (empty !== 1'b1) $display("FAIL drain_empty: got %0b want 1", empty); else passed++;
        checks++; if (free_count !== fl_ptr_t'(0)) $display("FAIL drain_count: got %0d want 0", free_count); else passed++;
        drive(2, 2'b00, '0, '0, 0, 1'b0);
        checks++; if (alloc_grant !== 1'b0) $display("FAIL drain_17th_grant: got %0b want 0", alloc_grant); else passed++;
        tick();
        checks++; if (free_count !== fl_ptr_t'(0)) $display("FAIL drain_hold: got %0d want 0", free_count); else passed++;
    endtask

    task automatic test_all_or_nothing();
        do_reset();
        for (int c = 0; c < 15; c++) begin
            drive(2, 2'b00, '0, '0, 0, 1'b0);
            e = exp_pop();
            e = exp_pop();
            tick();
        end
        drive(1, 2'b00, '0, '0, 0, 1'b0);
        e = exp_pop();
        tick();
        checks++; if (free_count !== fl_ptr_t'(1)) $display("FAIL aon_count1: got %0d want 1", free_count); else passed++;
        drive(2, 2'b00, '0, '0, 0, 1'b0);
        checks++; if (alloc_grant !== 1'b0) $display("FAIL aon_partial_grant: got %0b want 0", alloc_grant); else passed++;
        tick();
        checks++; if (free_count !== fl_ptr_t'(1)) $display("FAIL aon_head_hold: got %0d want 1", free_count); else passed++;
        drive(1, 2'b00, '0, '0, 0, 1'b0);
        checks++; if (alloc_grant !== 1'b1) $display("FAIL aon_single_grant: got %0b want 1", alloc_grant); else passed++;
        e = exp_pop();
        checks++; if (alloc_tag[0] !== e) $display("FAIL aon_tag: got %0d want %0d", alloc_tag[0], e); else passed++;
        tick();
        checks++; if (empty !== 1'b1) $display("FAIL aon_empty: got %0b want 1", empty); else passed++;
    endtask

    // Continues from the empty list left by test_all_or_nothing.
    task automatic test_compaction();
        drive(0, 2'b00, '0, '0, 2, 1'b0);
        tick();
        drive(0, 2'b00, '0, '0, 2, 1'b0);
        tick();
        drive(0, 2'b10, '0, phys_tag_t'(5), 0, 1'b0);
        exp_q.push_back(phys_tag_t'(5));
        tick();
        checks++; if (free_count !== fl_ptr_t'(1)) $display("FAIL cmp_count1: got %0d want 1", free_count); else passed++;
        drive(1, 2'b00, '0, '0, 0, 1'b0);
        checks++; if (alloc_grant !== 1'b1) $display("FAIL cmp_grant5: got %0b want 1", alloc_grant); else passed++;
        e = exp_pop();
        checks++; if (alloc_tag[0] !== e) $display("FAIL cmp_tag5: got %0d want %0d", alloc_tag[0], e); else passed++;
        tick();
        drive(0, 2'b11, phys_tag_t'(9), phys_tag_t'(8), 0, 1'b0);
        exp_q.push_back(phys_tag_t'(9));
        exp_q.push_back(phys_tag_t'(8));
        tick();
        checks++; if (free_count !== fl_ptr_t'(2)) $display("FAIL cmp_count2: got %0d want 2", free_count); else passed++;
        for (int c = 0; c < 2; c++) begin
            drive(1, 2'b00, '0, '0, 0, 1'b0);
            e = exp_pop();
            checks++; if (alloc_grant !== 1'b1 || alloc_tag[0] !== e)
                $display("FAIL cmp_pair c%0d: got grant %0b tag %0d want grant 1 tag %0d", c, alloc_grant, alloc_tag[0], e);
            else passed++;
            tick();
        end
        checks++; if (error !== 1'b0) $display("FAIL cmp_error: got %0b want 0", error); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(2, 2'b00, '0, '0, 0, 1'b0);
            e = exp_pop();
            checks++; if (alloc_tag[0] !== e) $display("FAIL flush_alloc c%0d: got %0d want %0d", c, alloc_tag[0], e); else passed++;
            e = exp_pop();
            tick();
        end
        drive(0, 2'b00, '0, '0, 2, 1'b0);
        tick();
        drive(1, 2'b00, '0, '0, 0, 1'b1);
        checks++; if (alloc_grant !== 1'b0) $display("FAIL flush_suppress: got %0b want 0", alloc_grant); else passed++;
        tick();
        for (int t = 37; t >= 34; t--) exp_q.push_front(phys_tag_t'(t));
        checks++; if (free_count !== fl_ptr_t'(30)) $display("FAIL flush_count: got %0d want 30", free_count); else passed++;
        drive(1, 2'b00, '0, '0, 0, 1'b0);
        e = exp_pop();
        checks++; if (alloc_grant !== 1'b1 || alloc_tag[0] !== e)
            $display("FAIL flush_tag: got grant %0b tag %0d want grant 1 tag %0d", alloc_grant, alloc_tag[0], e);
        else passed++;
        tick();
    endtask

    task automatic test_simul_empty();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(2, 2'b00, '0, '0, 0, 1'b0);
            e = exp_pop();
            e = exp_pop();
            tick();
        end
        drive(0, 2'b00, '0, '0, 2, 1'b0);
        tick();
        drive(1, 2'b01, phys_tag_t'(7), '0, 0, 1'b0);
        exp_q.push_back(phys_tag_t'(7));
        checks++; if (alloc_grant !== 1'b0) $display("FAIL simul_no_bypass: got %0b want 0", alloc_grant); else passed++;
        tick();
        drive(1, 2'b00, '0, '0, 0, 1'b0);
        e = exp_pop();
        checks++; if (alloc_grant !== 1'b1 || alloc_tag[0] !== e)
            $display("FAIL simul_next: got grant %0b tag %0d want grant 1 tag %0d", alloc_grant, alloc_tag[0], e);
        else passed++;
        tick();
        checks++; if (error !== 1'b0) $display("FAIL simul_error: got %0b want 0", error); else passed++;
    endtask

    task automatic test_errors();
        do_reset();
        drive(0, 2'b01, phys_tag_t'(3), '0, 0, 1'b0);
        tick();
        checks++; if (error !== 1'b1) $display("FAIL err_overflow: got %0b want 1", error); else passed++;
        checks++; if (free_count !== fl_ptr_t'(32)) $display("FAIL err_overflow_count: got %0d want 32", free_count); else passed++;
        drive(0, 2'b00, '0, '0, 1, 1'b0);
        tick();
        checks++; if (error !== 1'b1) $display("FAIL err_sticky: got %0b want 1", error); else passed++;
        do_reset();
        checks++; if (error !== 1'b0) $display("FAIL err_reset_clear: got %0b want 0", error); else passed++;
        drive(0, 2'b00, '0, '0, 1, 1'b0);
        tick();
        checks++; if (error !== 1'b1) $display("FAIL err_overcommit: got %0b want 1", error); else passed++;
        do_reset();
        drive(2, 2'b00, '0, '0, 0, 1'b0);
        tick();
        drive(0, 2'b00, '0, '0, 2, 1'b0);
        tick();
        checks++; if (error !== 1'b0) $display("FAIL err_exact_commit: got %0b want 0", error); else passed++;
        drive(0, 2'b00, '0, '0, 1, 1'b0);
        tick();
        checks++; if (error !== 1'b1) $display("FAIL err_commit_beyond: got %0b want 1", error); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        alloc_num = '0; free_valid = '0; free_tag = '0; commit_num = '0; flush = 1'b0;
        test_reset();
        test_drain();
        test_all_or_nothing();
        test_compaction();
        test_flush();
        test_simul_empty();
        test_errors();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
